rf_bank: RTL and testbench

//   Integer register file and responder end of the rf write-request/response handshake.

---
 rtl/rf_bank_if.sv | 14 +
 rtl/rf_bank.sv | 115 +++++++++++
 tb/tb_rf_bank.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_bank_if.sv
// Write request/response handshake between the writeback stage and the register file.
// The writeback stage is the master; rf_bank answers with a one-cycle done pulse.
interface rf_bank_if #(
    parameter int unsigned AW   = 5,
    parameter int unsigned XLEN = 32
);
    logic            en;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            done;

    modport master (output en, addr, data, input done);
    modport slave  (input en, addr, data, output done);
endinterface

// File: rtl/rf_bank.sv
// Integer register file: commits one handshaked write after WR_LATENCY cycles and serves
// NUM_RD combinational read ports, optionally forwarding the write being committed.
module rf_bank #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned WR_LATENCY = 1,
    parameter int unsigned BYPASS     = 1,
    localparam int unsigned AW        = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    rf_bank_if.slave               wr,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic                   busy
);

    if (WR_LATENCY < 1 || WR_LATENCY > 15) begin : g_bad_latency
        $error("rf_bank: WR_LATENCY must be in 1..15");
    end

    localparam logic [3:0] CntInit = (WR_LATENCY >= 2) ? 4'(WR_LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   cap_addr_q, cap_addr_d;
    logic [XLEN-1:0] cap_data_q, cap_data_d;
    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic            cap_ok;
    logic            commit;

    // x0 and out-of-range targets still handshake but never touch the array.
    assign cap_ok = (cap_addr_q != '0) && (32'(cap_addr_q) < NUM_REGS);
    assign commit = (state_q == StAck) && wr.en && cap_ok;
    assign busy   = (state_q != StIdle);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cap_addr_d = cap_addr_q;
        cap_data_d = cap_data_q;
        wr.done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (wr.en) begin
                    cap_addr_d = wr.addr;
                    cap_data_d = wr.data;
                    if (WR_LATENCY == 1) begin
                        state_d = StAck;
                    end else begin
                        cnt_d   = CntInit;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (!wr.en) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd0) begin
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAck: begin
                wr.done = wr.en;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            cap_addr_q <= '0;
            cap_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cap_addr_q <= cap_addr_d;
            cap_data_q <= cap_data_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            regs_q[cap_addr_q] <= cap_data_q;
        end
    end

    always_comb begin
        logic [AW-1:0] ra;
        ra      = '0;
        rd_data = '0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            ra = rd_addr[i*AW +: AW];
            if (ra != '0 && 32'(ra) < NUM_REGS) begin
                rd_data[i*XLEN +: XLEN] = regs_q[ra];
            end
            if (BYPASS != 0 && commit && ra == cap_addr_q) begin
                rd_data[i*XLEN +: XLEN] = cap_data_q;
            end
        end
    end

endmodule

// File: tb/tb_rf_bank.sv
// Bench for rf_bank: dut_a (latency 1, bypass) and dut_b (latency 3, no bypass) share clock
// and reset; done pulses are checked against a queue of expected cycles by a monitor.
module tb_rf_bank;
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NRD  = 2;
    localparam int          WLA  = 1;
    localparam int          WLB  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rf_bank_if #(.AW(AW), .XLEN(XLEN)) ifa ();
    rf_bank_if #(.AW(AW), .XLEN(XLEN)) ifb ();

    logic [NRD*AW-1:0]   rda, rdb;
    logic [NRD*XLEN-1:0] dda, ddb;
    logic                busya, busyb;

    rf_bank #(.XLEN(XLEN), .NUM_REGS(NREG), .NUM_RD(NRD), .WR_LATENCY(WLA), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .wr(ifa), .rd_addr(rda), .rd_data(dda), .busy(busya));
    rf_bank #(.XLEN(XLEN), .NUM_REGS(NREG), .NUM_RD(NRD), .WR_LATENCY(WLB), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .wr(ifb), .rd_addr(rdb), .rd_data(ddb), .busy(busyb));

    int n_chk = 0;
    int n_fail = 0;
    int exp_a[$];
    int exp_b[$];
    logic [31:0] model [2][NREG];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the next expected cycle.
    always @(negedge clk) begin
        if (ifa.done !== 1'b0) begin
            if (exp_a.size() == 0) chk("a_unexpected_done", 32'(ifa.done), 32'd0);
            else chk("a_done_cycle", cyc, exp_a.pop_front());
        end
        if (ifb.done !== 1'b0) begin
            if (exp_b.size() == 0) chk("b_unexpected_done", 32'(ifb.done), 32'd0);
            else chk("b_done_cycle", cyc, exp_b.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit s, input logic en, input logic [AW-1:0] a,
                         input logic [31:0] d);
        if (!s) begin ifa.en = en; ifa.addr = a; ifa.data = d; end
        else    begin ifb.en = en; ifb.addr = a; ifb.data = d; end
    endtask

    function automatic logic [31:0] port(input bit s, input int p);
        return s ? ddb[p*XLEN +: XLEN] : dda[p*XLEN +: XLEN];
    endfunction

    task automatic set_rd(input bit s, input int p, input logic [AW-1:0] a);
        if (!s) rda[p*AW +: AW] = a;
        else    rdb[p*AW +: AW] = a;
    endtask

    // Issues a request in the current cycle and queues its expected done cycle.
    task automatic start_write(input bit s, input logic [AW-1:0] a, input logic [31:0] d,
                               output int ic);
        drive(s, 1'b1, a, d);
        ic = cyc;
        if (!s) exp_a.push_back(cyc + WLA);
        else    exp_b.push_back(cyc + WLB);
    endtask

    // Returns at the falling edge of the ACK cycle, request still asserted.
    task automatic wait_done(input bit s, input logic [AW-1:0] a, input logic [31:0] d,
                             output int dc);
        bit ok = 1'b0;
        dc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((s ? ifb.done : ifa.done) === 1'b1) begin
                ok = 1'b1;
                dc = cyc;
                break;
            end
        end
        chk(s ? "b_done_seen" : "a_done_seen", 32'(ok), 32'd1);
        if (ok && a != '0) model[s][a] = d;
    endtask

    task automatic full_write(input bit s, input logic [AW-1:0] a, input logic [31:0] d);
        int ic, dc;
        step();
        start_write(s, a, d, ic);
        wait_done(s, a, d, dc);
        step();
        drive(s, 1'b0, '0, '0);
    endtask

    logic [AW-1:0] vec_a [8] = '{5'd1, 5'd2, 5'd31, 5'd0, 5'd9, 5'd2, 5'd16, 5'd7};
    logic [31:0]   vec_d [8] = '{32'hA5A5_0001, 32'h0000_00FF, 32'hFFFF_FFFF, 32'h0BAD_F00D,
                                 32'h1357_9BDF, 32'h2468_ACE0, 32'h8000_0000, 32'h7654_3210};

    initial begin
        int ic, dc, prev;
        for (int s = 0; s < 2; s++) for (int r = 0; r < int'(NREG); r++) model[s][r] = '0;
        drive(0, 1'b0, '0, '0);
        drive(1, 1'b0, '0, '0);
        rda = '0;
        rdb = '0;
        #1 rst = 1'b0;
        #2;
        chk("rst_busy_a", 32'(busya), 32'd0);
        chk("rst_busy_b", 32'(busyb), 32'd0);
        chk("rst_done_a", 32'(ifa.done), 32'd0);
        chk("rst_done_b", 32'(ifb.done), 32'd0);
        chk("rst_rd_a", dda[31:0] | dda[63:32], 32'd0);
        step();
        step();
        rst = 1'b1;

        // Latency 1 write of 0xDEADBEEF to x5.
        step();
        set_rd(0, 0, 5'd5);
        start_write(0, 5'd5, 32'hDEAD_BEEF, ic);
        @(negedge clk);
        chk("a_busy_req_cycle", 32'(busya), 32'd0);
        wait_done(0, 5'd5, 32'hDEAD_BEEF, dc);
        chk("a_latency", dc - ic, WLA);
        chk("a_busy_ack", 32'(busya), 32'd1);
        step();
        drive(0, 1'b0, '0, '0);
        chk("a_busy_after", 32'(busya), 32'd0);
        chk("a_x5", port(0, 0), 32'hDEAD_BEEF);

        // x0 stays zero before, during and after its write.
        set_rd(0, 0, 5'd0);
        #1 chk("a_x0_before", port(0, 0), 32'd0);
        step();
        start_write(0, 5'd0, 32'h1234, ic);
        wait_done(0, 5'd0, 32'h1234, dc);
        chk("a_x0_ack", port(0, 0), 32'd0);
        step();
        drive(0, 1'b0, '0, '0);
        chk("a_x0_after", port(0, 0), 32'd0);

        // Bypass: both ports on x7 see the new value in the ACK cycle.
        full_write(0, 5'd7, 32'h11);
        set_rd(0, 0, 5'd7);
        set_rd(0, 1, 5'd7);
        step();
        start_write(0, 5'd7, 32'h22, ic);
        wait_done(0, 5'd7, 32'h22, dc);
        chk("a_bypass_p1", port(0, 1), 32'h22);
        chk("a_bypass_p0", port(0, 0), 32'h22);
        step();
        drive(0, 1'b0, '0, '0);
        chk("a_x7_after", port(0, 1), 32'h22);

        // No bypass, latency 3: old value during ACK.
        set_rd(1, 1, 5'd7);
        full_write(1, 5'd7, 32'h11);
        step();
        start_write(1, 5'd7, 32'h22, ic);
        wait_done(1, 5'd7, 32'h22, dc);
        chk("b_latency", dc - ic, WLB);
        chk("b_nobypass_ack", port(1, 1), 32'h11);
        step();
        drive(1, 1'b0, '0, '0);
        chk("b_x7_after", port(1, 1), 32'h22);

        // Abort: en dropped two cycles after the request.
        set_rd(1, 0, 5'd9);
        step();
        drive(1, 1'b1, 5'd9, 32'h55);
        @(negedge clk) chk("b_abort_done0", 32'(ifb.done), 32'd0);
        step();
        @(negedge clk) chk("b_abort_done1", 32'(ifb.done), 32'd0);
        step();
        drive(1, 1'b0, 5'd9, 32'h55);
        @(negedge clk) chk("b_abort_done2", 32'(ifb.done), 32'd0);
        step();
        chk("b_abort_idle", 32'(busyb), 32'd0);
        chk("b_abort_reg", port(1, 0), 32'd0);
        @(negedge clk) chk("b_abort_done3", 32'(ifb.done), 32'd0);

        // Reset in the middle of a latency-3 wait.
        step();
        drive(1, 1'b1, 5'd3, 32'hABCD);
        step();
        chk("b_busy_wait", 32'(busyb), 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_mid_done_b", 32'(ifb.done), 32'd0);
        chk("rst_mid_busy_b", 32'(busyb), 32'd0);
        chk("rst_mid_busy_a", 32'(busya), 32'd0);
        for (int r = 0; r < int'(NREG); r++) begin
            set_rd(0, 0, AW'(r));
            set_rd(1, 0, AW'(r));
            #1;
            chk("rst_mid_rd_a", port(0, 0), 32'd0);
            chk("rst_mid_rd_b", port(1, 0), 32'd0);
        end
        for (int s = 0; s < 2; s++) for (int r = 0; r < int'(NREG); r++) model[s][r] = '0;
        drive(1, 1'b0, '0, '0);
        step();
        rst = 1'b1;
        set_rd(1, 0, 5'd3);
        step();
        step();
        step();
        chk("b_x3_after_rst", port(1, 0), 32'd0);

        // Back-to-back writes; request data is corrupted once captured.
        for (int s = 0; s < 2; s++) begin
            prev = -1;
            step();
            for (int i = 0; i < 8; i++) begin
                start_write(s[0], vec_a[i], vec_d[i], ic);
                step();
                drive(s[0], 1'b1, vec_a[i] ^ 5'h1f, ~vec_d[i]);
                wait_done(s[0], vec_a[i], vec_d[i], dc);
                if (prev >= 0) chk("b2b_spacing", dc - prev, (s == 0 ? WLA : WLB) + 1);
                prev = dc;
                step();
            end
            drive(s[0], 1'b0, '0, '0);
        end
        step();
        for (int r = 0; r < int'(NREG); r++) begin
            set_rd(0, 1, AW'(r));
            set_rd(1, 1, AW'(r));
            #1;
            chk("b2b_regs_a", port(0, 1), model[0][r]);
            chk("b2b_regs_b", port(1, 1), model[1][r]);
        end
        step();
        chk("sb_drained", 32'(exp_a.size() + exp_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule
